// File: rtl/ann_stage_eval.sv
// ann_stage_eval
// Cascade stage evaluator for one window scale. Signed weak-classifier
// outputs are summed per stage; at each stage boundary the sum is compared
// against a programmable signed threshold. The result is reported as a stage
// pass pulse, an early reject, or a final accept after the last stage.
//
// Optional feature: define ACC_SATURATE_EN to clamp the accumulator to the
// signed ACC_W range. When it is undefined, the accumulator wraps at ACC_W
// bits.
//
// Ports:
//   iClk, iReset_n  : clock, asynchronous active-low reset
//   iRun            : window-active level from the controller
//   iFeature_valid  : classifier output present this cycle
//   iFeature_value  : signed classifier output (VAL_W)
//   iThr_we         : threshold write strobe (honoured in IDLE only)
//   iThr_addr       : stage index of the threshold write (0..NUM_STAGES-1)
//   iThr_data       : signed threshold (ACC_W)
//   oFinish_Stage   : pulse, stage passed and more stages remain
//   oFinish_ANN     : pulse, window decision is final
//   oPass_ANN       : decision flag, held until the next window starts
//   oStage          : current stage index
//   oBusy           : registered, high while accumulating or comparing
//   oError          : sticky protocol-violation flag
module ann_stage_eval #(
  parameter int ACC_W      = 20,
  parameter int VAL_W      = 16,
  parameter int NUM_STAGES = 9,
  parameter int B1 = 3,
  parameter int B2 = 9,
  parameter int B3 = 15,
  parameter int B4 = 21,
  parameter int B5 = 33,
  parameter int B6 = 49,
  parameter int B7 = 61,
  parameter int B8 = 81,
  parameter int B9 = 115
) (
  input  logic             iClk,
  input  logic             iReset_n,
  input  logic             iRun,
  input  logic             iFeature_valid,
  input  logic [VAL_W-1:0] iFeature_value,
  input  logic             iThr_we,
  input  logic [3:0]       iThr_addr,
  input  logic [ACC_W-1:0] iThr_data,
  output logic             oFinish_Stage,
  output logic             oFinish_ANN,
  output logic             oPass_ANN,
  output logic [3:0]       oStage,
  output logic             oBusy,
  output logic             oError
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCUM   = 2'd1,
    S_COMPARE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t                  r_state;
  logic signed [ACC_W-1:0] r_acc;
  logic [6:0]              r_count;
  logic [3:0]              r_stage;
  logic signed [ACC_W-1:0] r_thr [NUM_STAGES];
  logic                    r_finish_stage;
  logic                    r_finish_ann;
  logic                    r_pass;
  logic                    r_busy;
  logic                    r_error;

  logic signed [ACC_W-1:0] w_val_ext;
  logic signed [ACC_W-1:0] w_acc_next;
  logic signed [ACC_W-1:0] w_thr_sel;
  logic                    w_last_feature;
  logic                    w_last_stage;
  logic                    w_ge;

  // Cumulative feature count at which the given stage closes.
  function automatic logic [6:0] f_boundary(input logic [3:0] stage);
    case (stage)
      4'd0:    return 7'(B1);
      4'd1:    return 7'(B2);
      4'd2:    return 7'(B3);
      4'd3:    return 7'(B4);
      4'd4:    return 7'(B5);
      4'd5:    return 7'(B6);
      4'd6:    return 7'(B7);
      4'd7:    return 7'(B8);
      default: return 7'(B9);
    endcase
  endfunction

  assign w_val_ext = {{(ACC_W-VAL_W){iFeature_value[VAL_W-1]}}, iFeature_value};

`ifdef ACC_SATURATE_EN
  logic [ACC_W:0] w_sum_wide;

  // One extra bit exposes overflow; disagreeing top bits mean the sum left range.
  assign w_sum_wide = {r_acc[ACC_W-1], r_acc} + {w_val_ext[ACC_W-1], w_val_ext};

  // Clamp to the signed ACC_W range on overflow.
  always_comb begin
    w_acc_next = w_sum_wide[ACC_W-1:0];
    if (w_sum_wide[ACC_W] != w_sum_wide[ACC_W-1]) begin
      if (w_sum_wide[ACC_W]) begin
        w_acc_next = {1'b1, {(ACC_W-1){1'b0}}};
      end else begin
        w_acc_next = {1'b0, {(ACC_W-1){1'b1}}};
      end
    end else begin
      w_acc_next = w_sum_wide[ACC_W-1:0];
    end
  end
`else
  // Plain ACC_W-bit adder: low bits of the wide sum, i.e. two's-complement wrap.
  assign w_acc_next = r_acc + w_val_ext;
`endif

  assign w_thr_sel      = r_thr[r_stage];
  assign w_ge           = (r_acc >= w_thr_sel);
  assign w_last_feature = ((r_count + 7'd1) == f_boundary(r_stage));
  assign w_last_stage   = (r_stage == 4'(NUM_STAGES - 1));

  // Stage-evaluation FSM with registered pulses, flags and threshold table.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_state        <= S_IDLE;
      r_acc          <= '0;
      r_count        <= 7'd0;
      r_stage        <= 4'd0;
      r_finish_stage <= 1'b0;
      r_finish_ann   <= 1'b0;
      r_pass         <= 1'b0;
      r_busy         <= 1'b0;
      r_error        <= 1'b0;
      for (int i = 0; i < NUM_STAGES; i++) begin
        r_thr[i] <= '0;
      end
    end else begin
      r_finish_stage <= 1'b0;
      r_finish_ann   <= 1'b0;
      r_busy         <= (r_state == S_ACCUM) || (r_state == S_COMPARE);
      case (r_state)
        S_IDLE: begin
          if (iThr_we && (iThr_addr < 4'(NUM_STAGES))) begin
            r_thr[iThr_addr] <= iThr_data;
          end
          if (iFeature_valid) begin
            r_error <= 1'b1;
          end
          if (iRun) begin
            r_acc   <= '0;
            r_count <= 7'd0;
            r_stage <= 4'd0;
            r_pass  <= 1'b0;
            r_state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          // Abort takes priority over a feature arriving in the same cycle.
          if (!iRun) begin
            r_state <= S_IDLE;
          end else if (iFeature_valid) begin
            r_acc   <= w_acc_next;
            r_count <= r_count + 7'd1;
            if (w_last_feature) begin
              r_state <= S_COMPARE;
            end
          end
        end
        S_COMPARE: begin
          if (iFeature_valid) begin
            r_error <= 1'b1;
          end
          if (!iRun) begin
            r_state <= S_IDLE;
          end else if (w_ge && !w_last_stage) begin
            // Count keeps running across stages; only the sum restarts.
            r_finish_stage <= 1'b1;
            r_stage        <= r_stage + 4'd1;
            r_acc          <= '0;
            r_state        <= S_ACCUM;
          end else begin
            r_finish_ann <= 1'b1;
            r_pass       <= w_ge;
            r_state      <= S_DONE;
          end
        end
        S_DONE: begin
          if (iFeature_valid) begin
            r_error <= 1'b1;
          end
          if (!iRun) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign oFinish_Stage = r_finish_stage;
  assign oFinish_ANN   = r_finish_ann;
  assign oPass_ANN     = r_pass;
  assign oStage        = r_stage;
  assign oBusy         = r_busy;
  assign oError        = r_error;

endmodule

// File: tb/tb_ann_stage_eval.sv
// Randomised scoreboard bench for ann_stage_eval. The driver computes each
// stage sum from the cascade rules and queues the expected pulse; a monitor
// pops and compares whenever the DUT raises a finish pulse.
module tb_ann_stage_eval;

  logic        iClk = 1'b0;
  logic        iReset_n = 1'b0;
  logic        iRun = 1'b0;
  logic        iFeature_valid = 1'b0;
  logic [15:0] iFeature_value = 16'd0;
  logic        iThr_we = 1'b0;
  logic [3:0]  iThr_addr = 4'd0;
  logic [19:0] iThr_data = 20'd0;
  logic        oFinish_Stage;
  logic        oFinish_ANN;
  logic        oPass_ANN;
  logic [3:0]  oStage;
  logic        oBusy;
  logic        oError;

  ann_stage_eval dut (
    .iClk(iClk), .iReset_n(iReset_n), .iRun(iRun),
    .iFeature_valid(iFeature_valid), .iFeature_value(iFeature_value),
    .iThr_we(iThr_we), .iThr_addr(iThr_addr), .iThr_data(iThr_data),
    .oFinish_Stage(oFinish_Stage), .oFinish_ANN(oFinish_ANN),
    .oPass_ANN(oPass_ANN), .oStage(oStage), .oBusy(oBusy), .oError(oError)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    int cyc;
    bit is_ann;
    bit pass;
    int stage;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  total = 0;
  int  bad = 0;
  bit  err_exp = 1'b0;
  int  vals[115];
  int  thr_m[9];
  int  bnd[9] = '{3, 9, 15, 21, 33, 49, 61, 81, 115};

  always @(posedge iClk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Accumulator narrowing: clamp when saturating, otherwise 20-bit wrap.
  function automatic int narrow(input longint x);
`ifdef ACC_SATURATE_EN
    if (x > 524287) return 524287;
    if (x < -524288) return -524288;
    return int'(x);
`else
    longint m;
    m = x % 1048576;
    if (m < 0) m += 1048576;
    if (m >= 524288) m -= 1048576;
    return int'(m);
`endif
  endfunction

  // Monitor: every finish pulse must match the head of the expected queue.
  always @(posedge iClk) begin
    #1;
    if (oFinish_Stage || oFinish_ANN) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse: got stage_pulse=%0b ann_pulse=%0b expected none (cycle %0d)",
                 oFinish_Stage, oFinish_ANN, cyc);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if (oFinish_Stage !== !e.is_ann || oFinish_ANN !== e.is_ann ||
            int'(oStage) != e.stage || cyc != e.cyc ||
            (e.is_ann && oPass_ANN !== e.pass)) begin
          bad++;
          $display("FAIL pulse: got stg=%0b ann=%0b pass=%0b oStage=%0d cyc=%0d expected stg=%0b ann=%0b pass=%0b oStage=%0d cyc=%0d",
                   oFinish_Stage, oFinish_ANN, oPass_ANN, oStage, cyc,
                   !e.is_ann, e.is_ann, e.pass, e.stage, e.cyc);
        end
      end
    end
  end

  task automatic program_thr();
    for (int s = 0; s < 16; s++) begin
      @(negedge iClk);
      iThr_we   = 1'b1;
      iThr_addr = 4'(s);
      iThr_data = (s < 9) ? 20'(thr_m[s]) : 20'($urandom);
    end
    @(negedge iClk);
    iThr_we = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_fin_stage"}, int'(oFinish_Stage), 0);
    check({tag, "_fin_ann"}, int'(oFinish_ANN), 0);
    check({tag, "_pass"}, int'(oPass_ANN), 0);
    check({tag, "_stage"}, int'(oStage), 0);
    check({tag, "_busy"}, int'(oBusy), 0);
    check({tag, "_error"}, int'(oError), 0);
  endtask

  // One window. abort_at / reset_at: feature index where iRun drops (with
  // that feature driven) or reset is pulsed; -1 disables.
  task automatic run_window(input int abort_at, input int reset_at,
                            input bit bubble_err, input int gap_max);
    int  acc;
    int  stage;
    bit  decided;
    bit  last_pass;
    ev_t e;
    acc = 0; stage = 0; decided = 1'b0; last_pass = 1'b0;
    @(negedge iClk);
    iRun = 1'b1;
    @(posedge iClk);
    #1;
    check("start_stage", int'(oStage), 0);
    check("start_pass", int'(oPass_ANN), 0);
    for (int i = 0; i < 115 && !decided; i++) begin
      int ng;
      ng = int'($urandom_range(0, gap_max));
      repeat (ng) begin
        @(negedge iClk);
        iFeature_valid = 1'b0;
      end
      @(negedge iClk);
      if (i == reset_at) begin
        iFeature_valid = 1'b0;
        iReset_n = 1'b0;
        #1;
        check_outputs_zero("async_rst");
        check("async_rst_queue", exp_q.size(), 0);
        repeat (2) @(negedge iClk);
        iRun = 1'b0;
        iReset_n = 1'b1;
        for (int s = 0; s < 9; s++) thr_m[s] = 0;
        err_exp = 1'b0;
        repeat (2) @(negedge iClk);
        return;
      end
      iFeature_valid = 1'b1;
      iFeature_value = 16'(vals[i]);
      if (i == abort_at) begin
        iRun = 1'b0;
        @(negedge iClk);
        iFeature_valid = 1'b0;
        repeat (2) @(negedge iClk);
        check("abort_busy", int'(oBusy), 0);
        check("abort_no_pulse", exp_q.size(), 0);
        return;
      end
      acc = narrow(longint'(acc) + longint'(vals[i]));
      if (i + 1 == bnd[stage]) begin
        bit p;
        p = (acc >= thr_m[stage]);
        e.cyc    = cyc + 2;
        e.is_ann = !p || (stage == 8);
        e.pass   = p;
        e.stage  = (p && stage < 8) ? stage + 1 : stage;
        exp_q.push_back(e);
        @(negedge iClk);
        if (bubble_err) begin
          iFeature_valid = 1'b1;
          iFeature_value = 16'($urandom);
          err_exp = 1'b1;
        end else begin
          iFeature_valid = 1'b0;
        end
        if (e.is_ann) begin
          decided = 1'b1;
          last_pass = p;
        end else begin
          stage++;
          acc = 0;
        end
      end
    end
    @(negedge iClk);
    iFeature_valid = 1'b0;
    repeat (3) @(negedge iClk);
    check("win_queue_empty", exp_q.size(), 0);
    check("win_pass_held", int'(oPass_ANN), int'(last_pass));
    check("win_error", int'(oError), int'(err_exp));
    iRun = 1'b0;
    repeat (3) @(negedge iClk);
    check("idle_busy", int'(oBusy), 0);
  endtask

  task automatic fill_vals(input int v);
    for (int i = 0; i < 115; i++) vals[i] = v;
  endtask

  task automatic fill_thr(input int t);
    for (int s = 0; s < 9; s++) thr_m[s] = t;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge iClk);
    check_outputs_zero("reset");
    iReset_n = 1'b1;
    repeat (2) @(negedge iClk);

    // Full accept: all thresholds 0, 115 x (+1) back-to-back.
    fill_thr(0); program_thr();
    fill_vals(1);
    run_window(-1, -1, 1'b0, 0);

    // Early reject at stage 1.
    fill_thr(0); thr_m[1] = 10; program_thr();
    fill_vals(1);
    vals[0] = 5; vals[1] = 5; vals[2] = 5;
    run_window(-1, -1, 1'b0, 0);

    // Large positive sum in stage 4 against the top threshold.
    fill_thr(0); thr_m[4] = 524287; program_thr();
    fill_vals(0);
    for (int i = 21; i < 33; i++) vals[i] = 32767;
    run_window(-1, -1, 1'b0, 0);

    // Large negative sum in stage 4 against -1.
    thr_m[4] = -1; program_thr();
    for (int i = 21; i < 33; i++) vals[i] = -32768;
    run_window(-1, -1, 1'b0, 0);

    // Stage 8 sum beyond range: clamps or wraps depending on the build.
    fill_thr(0); thr_m[8] = 524287; program_thr();
    fill_vals(0);
    for (int i = 81; i < 115; i++) vals[i] = 32767;
    run_window(-1, -1, 1'b0, 1);

    // Abort with iRun falling together with the stage-1 closing feature.
    fill_thr(0); program_thr();
    fill_vals(1);
    run_window(8, -1, 1'b0, 0);
    run_window(-1, -1, 1'b0, 0);

    // Protocol violation during every COMPARE cycle.
    fill_vals(1);
    thr_m[2] = 6; program_thr();
    run_window(-1, -1, 1'b1, 0);

    // Randomised windows: small values, then full-range values.
    for (int w = 0; w < 12; w++) begin
      for (int s = 0; s < 9; s++) begin
        if (w < 6) thr_m[s] = int'($urandom_range(0, 40)) - 10;
        else thr_m[s] = int'($urandom_range(0, 1048575)) - 524288;
      end
      for (int i = 0; i < 115; i++) begin
        if (w < 6) vals[i] = int'($urandom_range(0, 12)) - 3;
        else vals[i] = int'($urandom_range(0, 65535)) - 32768;
      end
      program_thr();
      run_window(-1, -1, 1'b0, 2);
    end

    // Async reset mid-stage 5, then an all-zero window must pass everywhere.
    fill_thr(1); program_thr();
    fill_vals(1);
    run_window(-1, 40, 1'b0, 0);
    fill_vals(0);
    run_window(-1, -1, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
